// File: rtl/controle_pkg.sv
// ---------------------------------------------------------------------------
// controle_pkg
// Shared definitions for the push-button conditioning stage that feeds the
// 0-7 up/down counter: debouncer state encoding, direction constants and
// default timing parameters.
// Configuration macro used by the block: CONTROLE_AUTO_EN (auto-step feature).
// ---------------------------------------------------------------------------
package controle_pkg;

    // Debouncer FSM states
    typedef enum logic [1:0] {
        IDLE         = 2'd0,  // released, waiting for a press
        CONF_PRESS   = 2'd1,  // press seen, confirming it stays stable
        PRESSED      = 2'd2,  // press accepted, button held
        CONF_RELEASE = 2'd3   // release seen, confirming it stays stable
    } deb_state_e;

    // Direction level handed to the counter
    localparam logic MODO_ASC  = 1'b1;
    localparam logic MODO_DESC = 1'b0;

    // Defaults sized for a 50 MHz board clock (1 ms debounce, 0.5 s auto step)
    localparam int DEBOUNCE_CYCLES_DEF = 50000;
    localparam int AUTO_PERIOD_DEF     = 25000000;

endpackage

// File: rtl/controle_contador_debouncer.sv
// ---------------------------------------------------------------------------
// debouncer
// Synchronizes one active-low push button and debounces it with a
// four-state FSM. A press is accepted after DEBOUNCE_CYCLES+1 consecutive
// pressed samples; a release likewise needs a stable run of released samples.
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles required to accept a press/release (>= 2)
// Ports:
//   clock   in   system clock, posedge
//   reset   in   asynchronous active-low reset
//   btn_n   in   raw button, active-low, asynchronous to clock
//   press   out  one-cycle strobe on the CONF_PRESS -> PRESSED transition
//   nivel   out  debounced level, 1 = pressed
// ---------------------------------------------------------------------------
module debouncer
    import controle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_n,
    output logic press,
    output logic nivel
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          pressed;
    deb_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_sat;

    // Two-flop synchronizer; resets to the released level so a button held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], btn_n};
        end
    end

    assign pressed = ~sync_q[1];

    // Counter never wraps, even if it were left counting
    assign cnt_sat = (&cnt_q) ? cnt_q : cnt_q + CW'(1);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pressed) begin
                        state_q <= CONF_PRESS;
                        cnt_q   <= '0;
                    end
                end
                CONF_PRESS: begin
                    if (!pressed) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= PRESSED;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                PRESSED: begin
                    if (!pressed) begin
                        state_q <= CONF_RELEASE;
                        cnt_q   <= '0;
                    end
                end
                CONF_RELEASE: begin
                    if (pressed) begin
                        state_q <= PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_sat;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Strobe is decoded from the transition condition so the single output
    // register in the top is the only stage between acceptance and passo.
    assign press = (state_q == CONF_PRESS) && pressed && (cnt_q == CNT_LAST);
    assign nivel = (state_q == PRESSED) || (state_q == CONF_RELEASE);

endmodule

// File: rtl/controle_contador.sv
// ---------------------------------------------------------------------------
// controle_contador
// Input conditioning for the 0-7 up/down counter. Debounces the step and mode
// push buttons, generates a one-cycle step pulse and a direction level that
// toggles on each mode press.
//
// Configuration macro: CONTROLE_AUTO_EN
//   defined   -> adds auto_sw and a prescaler that also pulses passo every
//                AUTO_PERIOD cycles while auto_sw = 1
//   undefined -> passo comes from the step button only
//
// Parameters:
//   DEBOUNCE_CYCLES  debounce length in cycles (>= 2)
//   AUTO_PERIOD      auto-step period in cycles (CONTROLE_AUTO_EN only)
// Ports:
//   clock      in   system clock, posedge
//   reset      in   asynchronous active-low reset
//   btn_passo  in   step button, active-low, asynchronous
//   btn_modo   in   mode button, active-low, asynchronous
//   auto_sw    in   auto-step enable, active-high (CONTROLE_AUTO_EN only)
//   passo      out  one-cycle step pulse, registered
//   modo       out  direction, 1 = ascending, 0 = descending, registered
// ---------------------------------------------------------------------------
module controle_contador
    import controle_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef CONTROLE_AUTO_EN
    ,
    parameter int AUTO_PERIOD     = AUTO_PERIOD_DEF
`endif
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_passo,
    input  logic btn_modo,
`ifdef CONTROLE_AUTO_EN
    input  logic auto_sw,
`endif
    output logic passo,
    output logic modo
);

    logic press_passo;
    logic press_modo;
    logic nivel_passo;
    logic nivel_modo;
    logic auto_tick;
    logic passo_q;
    logic modo_q;
    logic unused_nivel;

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_passo (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_passo),
        .press (press_passo),
        .nivel (nivel_passo)
    );

    debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb_modo (
        .clock (clock),
        .reset (reset),
        .btn_n (btn_modo),
        .press (press_modo),
        .nivel (nivel_modo)
    );

    // Debounced levels are not needed by the counter path
    assign unused_nivel = &{1'b0, nivel_passo, nivel_modo};

`ifdef CONTROLE_AUTO_EN
    localparam int AW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [AW-1:0] PRESC_LAST = AW'(AUTO_PERIOD - 1);

    logic [AW-1:0] presc_q;

    assign auto_tick = auto_sw && (presc_q == PRESC_LAST);

    // Held at zero while disabled so the first tick lands a full period
    // after auto_sw rises.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else if (!auto_sw || auto_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + AW'(1);
        end
    end
`else
    assign auto_tick = 1'b0;
`endif

    // Both registers update on the same edge, so a simultaneous mode press
    // reaches the counter together with the step pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            passo_q <= 1'b0;
            modo_q  <= MODO_ASC;
        end else begin
            passo_q <= press_passo | auto_tick;
            if (press_modo) begin
                modo_q <= (modo_q == MODO_ASC) ? MODO_DESC : MODO_ASC;
            end
        end
    end

    assign passo = passo_q;
    assign modo  = modo_q;

endmodule

// File: tb/tb_controle_contador.sv
// ---------------------------------------------------------------------------
// tb_controle_contador
// Randomized and directed stimulus for controle_contador with a behavioural
// reference: a button press is accepted once DEBOUNCE_CYCLES+1 consecutive
// samples disagree with the current debounced level, and the resulting output
// event appears two cycles after the accepting sample. Auto steps (when
// CONTROLE_AUTO_EN is defined) occur every AUTO_PERIOD enabled cycles.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_controle_contador;

    localparam int D = 4;
`ifdef CONTROLE_AUTO_EN
    localparam int P = 10;
`endif

    // ---------------- clock / reset ----------------
    logic clock     = 1'b0;
    logic reset     = 1'b0;
    logic btn_passo = 1'b1;
    logic btn_modo  = 1'b1;
`ifdef CONTROLE_AUTO_EN
    logic auto_sw   = 1'b0;
`endif
    logic passo;
    logic modo;

    always #5 clock = ~clock;

    controle_contador #(
        .DEBOUNCE_CYCLES(D)
`ifdef CONTROLE_AUTO_EN
        ,
        .AUTO_PERIOD(P)
`endif
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_passo (btn_passo),
        .btn_modo  (btn_modo),
`ifdef CONTROLE_AUTO_EN
        .auto_sw   (auto_sw),
`endif
        .passo     (passo),
        .modo      (modo)
    );

    // ---------------- scoreboard state ----------------
    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [33:0] exp_q[$];   // {cycle, passo, modo} output events
    logic [32:0] pend_q[$];  // {due cycle, 1 = mode button} accepted presses

    // reference model state
    logic lvl_p  = 1'b0;
    logic lvl_m  = 1'b0;
    int   run_p  = 0;
    int   run_m  = 0;
    logic modo_m = 1'b1;
    int   en_cnt = 0;

    task automatic check(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %b, expected %b", name, cyc, got, exp);
        end
    endtask

    // One sample of the run-length debounce model
    task automatic deb_step(input logic pressed, inout logic lvl, inout int run,
                            output logic accepted);
        accepted = 1'b0;
        if (pressed != lvl) run++;
        else                run = 0;
        if (run == D + 1) begin
            lvl      = pressed;
            run      = 0;
            accepted = pressed;
        end
    endtask

    // ---------------- reference model ----------------
    initial begin
        logic acc;
        logic p;
        logic t;
        logic [32:0] e;
        forever begin
            @(posedge clock);
            cyc++;
            if (!reset) begin
                lvl_p = 1'b0; lvl_m = 1'b0; run_p = 0; run_m = 0;
                modo_m = 1'b1; en_cnt = 0;
                pend_q.delete();
                exp_q.delete();
            end else begin
                deb_step(!btn_passo, lvl_p, run_p, acc);
                if (acc) pend_q.push_back({32'(cyc + 2), 1'b0});
                deb_step(!btn_modo, lvl_m, run_m, acc);
                if (acc) pend_q.push_back({32'(cyc + 2), 1'b1});
                p = 1'b0;
                t = 1'b0;
`ifdef CONTROLE_AUTO_EN
                if (auto_sw) begin
                    en_cnt++;
                    if (en_cnt == P) begin
                        p = 1'b1;
                        en_cnt = 0;
                    end
                end else begin
                    en_cnt = 0;
                end
`endif
                while (pend_q.size() > 0 && pend_q[0][32:1] == 32'(cyc)) begin
                    e = pend_q.pop_front();
                    if (e[0]) t = 1'b1;
                    else      p = 1'b1;
                end
                if (p || t) begin
                    modo_m = modo_m ^ t;
                    exp_q.push_back({32'(cyc), p, modo_m});
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        logic e_passo;
        logic e_modo;
        logic [33:0] rec;
        e_modo = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            e_passo = 1'b0;
            if (!reset) begin
                e_modo = 1'b1;
            end else begin
                while (exp_q.size() > 0 && exp_q[0][33:2] < 32'(cyc)) begin
                    rec = exp_q.pop_front();
                    check("lost_event", 1'b0, 1'b1);
                end
                if (exp_q.size() > 0 && exp_q[0][33:2] == 32'(cyc)) begin
                    rec     = exp_q.pop_front();
                    e_passo = rec[1];
                    e_modo  = rec[0];
                end
            end
            check("passo", passo, e_passo);
            check("modo", modo, e_modo);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press_step(input int hold, input int gap);
        btn_passo = 1'b0; cycles(hold);
        btn_passo = 1'b1; cycles(gap);
    endtask

    task automatic press_mode(input int hold, input int gap);
        btn_modo = 1'b0; cycles(hold);
        btn_modo = 1'b1; cycles(gap);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int hold_p;
        int hold_m;

        // reset, then idle
        reset = 1'b0; cycles(3);
        reset = 1'b1; cycles(20);

        // clean presses: held 30, then again 10 cycles after release
        press_step(30, 10);
        press_step(12, 12);

        // bounce every 2 cycles for 40 cycles, then a solid press
        for (int i = 0; i < 20; i++) begin
            btn_passo = ~btn_passo;
            cycles(2);
        end
        press_step(10, 12);

        // three mode presses, then simultaneous step + mode
        for (int i = 0; i < 3; i++) press_mode(10, 10);
        btn_passo = 1'b0; btn_modo = 1'b0; cycles(10);
        btn_passo = 1'b1; btn_modo = 1'b1; cycles(12);

        // leave modo descending, then reset in the middle of a step press
        press_mode(10, 12);
        btn_passo = 1'b0; cycles(4);
        reset = 1'b0; cycles(3);
        reset = 1'b1; cycles(12);
        btn_passo = 1'b1; cycles(12);

        // random button activity with occasional resets
        hold_p = 0;
        hold_m = 0;
        for (int i = 0; i < 400; i++) begin
            if (hold_p == 0) begin
                btn_passo = 1'($urandom_range(0, 1));
                hold_p    = $urandom_range(1, 8);
            end
            if (hold_m == 0) begin
                btn_modo = 1'($urandom_range(0, 1));
                hold_m   = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 149) == 0) begin
                reset = 1'b0; cycles(2);
                reset = 1'b1;
            end
            hold_p--;
            hold_m--;
            cycles(1);
        end
        btn_passo = 1'b1; btn_modo = 1'b1; cycles(15);

`ifdef CONTROLE_AUTO_EN
        // auto for 35 cycles; step press lands on the second auto tick
        auto_sw = 1'b1; cycles(13);
        btn_passo = 1'b0; cycles(10);
        btn_passo = 1'b1; cycles(12);
        auto_sw = 1'b0; cycles(25);
`endif

        cycles(20);
        check("exp_queue_drained", 1'(exp_q.size() == 0), 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
